// File: rtl/ram_bus_arbiter_pkg.sv
// Shared definitions for the serial RAM bus arbiter: FSM states, requester IDs,
// SPI opcodes and the 32-bit command frame layout.
package ram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_MCU = 1'b0,
    REQ_COP = 1'b1
  } requester_t;

  localparam logic [7:0] RAM_OP_READ  = 8'h03;
  localparam logic [7:0] RAM_OP_WRITE = 8'h02;
  localparam int FRAME_LEN  = 32;
  localparam int HALF_CNT_W = $clog2(2 * FRAME_LEN);

  // Frame is opcode, 16-bit address, then the data byte (dummy zero for reads).
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic we,
                                                       input logic [15:0] addr,
                                                       input logic [7:0] wdata);
    return {(we ? RAM_OP_WRITE : RAM_OP_READ), addr, (we ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_spi_shifter.sv
// SPI mode-0 frame engine: two clocks per bit, MSB first, samples MISO at the
// end of each high phase and exposes the last received byte.
module ram_spi_shifter
  import ram_bus_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [FRAME_LEN-1:0] frame,
  input  logic                 shift_en,
  input  logic                 miso,
  output logic                 mosi,
  output logic                 sck_phase,
  output logic                 last,
  output logic [7:0]           rx_byte
);

  logic [FRAME_LEN-1:0]  shift_q;
  logic [HALF_CNT_W-1:0] half_cnt_q;
  logic [6:0]            rx_q;

  // Odd half-count is the high phase; its closing edge advances MOSI and samples MISO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      half_cnt_q <= '0;
      rx_q       <= '0;
    end else if (load) begin
      shift_q    <= frame;
      half_cnt_q <= '0;
      rx_q       <= '0;
    end else if (shift_en) begin
      half_cnt_q <= half_cnt_q + HALF_CNT_W'(1);
      if (half_cnt_q[0]) begin
        shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
        rx_q    <= {rx_q[5:0], miso};
      end
    end
  end

  assign mosi      = shift_q[FRAME_LEN-1];
  assign sck_phase = half_cnt_q[0];
  assign last      = (half_cnt_q == HALF_CNT_W'(2 * FRAME_LEN - 1));
  assign rx_byte   = {rx_q, miso};

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-master (MCU/COP) arbiter onto a single SPI serial RAM, one byte per transaction.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise MCU has fixed priority.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mcu_req,
  input  logic                  mcu_we,
  input  logic [ADDR_WIDTH-1:0] mcu_addr,
  input  logic [DATA_WIDTH-1:0] mcu_wdata,
  output logic                  mcu_ack,
  input  logic                  cop_req,
  input  logic                  cop_we,
  input  logic [ADDR_WIDTH-1:0] cop_addr,
  input  logic [DATA_WIDTH-1:0] cop_wdata,
  output logic                  cop_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  ram_nss,
  output logic                  ram_sck,
  output logic                  ram_mosi,
  input  logic                  ram_miso
);

  arb_state_t state_q, state_d;
  requester_t grant_q, winner;
  logic       we_q;

  logic                  load, shift_en;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [FRAME_LEN-1:0]  frame_d;
  logic                  shift_mosi, sck_phase, frame_last;
  logic [7:0]            rx_byte;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  requester_t ptr_q;

  // Pointer names the requester that wins the next tie: whoever was not just served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= REQ_MCU;
    end else if (state_q == ST_DONE) begin
      ptr_q <= (grant_q == REQ_MCU) ? REQ_COP : REQ_MCU;
    end
  end
`endif

  always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (mcu_req && cop_req) begin
      winner = ptr_q;
    end else if (mcu_req) begin
      winner = REQ_MCU;
    end else begin
      winner = REQ_COP;
    end
`else
    winner = mcu_req ? REQ_MCU : REQ_COP;
`endif
    sel_we    = (winner == REQ_COP) ? cop_we    : mcu_we;
    sel_addr  = (winner == REQ_COP) ? cop_addr  : mcu_addr;
    sel_wdata = (winner == REQ_COP) ? cop_wdata : mcu_wdata;
    frame_d   = build_frame(sel_we, 16'(sel_addr), 8'(sel_wdata));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant and direction are frozen at grant so later input changes cannot disturb the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q <= REQ_MCU;
      we_q    <= 1'b0;
    end else if (load) begin
      grant_q <= winner;
      we_q    <= sel_we;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (shift_en && frame_last && !we_q) begin
      rdata <= DATA_WIDTH'(rx_byte);
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b1;
    ram_nss  = 1'b1;
    ram_sck  = 1'b0;
    ram_mosi = 1'b0;
    mcu_ack  = 1'b0;
    cop_ack  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (mcu_req || cop_req) begin
          load    = 1'b1;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        ram_nss  = 1'b0;
        ram_mosi = shift_mosi;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        ram_nss  = 1'b0;
        ram_sck  = sck_phase;
        ram_mosi = shift_mosi;
        shift_en = 1'b1;
        if (frame_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        mcu_ack = (grant_q == REQ_MCU);
        cop_ack = (grant_q == REQ_COP);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ram_spi_shifter u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .frame     (frame_d),
    .shift_en  (shift_en),
    .miso      (ram_miso),
    .mosi      (shift_mosi),
    .sck_phase (sck_phase),
    .last      (frame_last),
    .rx_byte   (rx_byte)
  );

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: SPI serial RAM device model plus a transaction-level
// reference (winner choice, expected frame, ack timing, expected read byte).
module tb_ram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mcu_req = 1'b0, mcu_we = 1'b0, cop_req = 1'b0, cop_we = 1'b0;
  logic [15:0] mcu_addr = '0, cop_addr = '0;
  logic [7:0]  mcu_wdata = '0, cop_wdata = '0;
  logic        mcu_ack, cop_ack, busy, ram_nss, ram_sck, ram_mosi;
  logic        ram_miso = 1'b0;
  logic [7:0]  rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  ram_mem [0:65535];
  logic [31:0] spi_shift = '0;
  int          spi_bits = 0;
  logic [7:0]  spi_rd_byte = '0;
  logic [31:0] last_frame = '0;
  int          last_bits = 0;
  time         rise_t = 0;
  time         last_gap = 0;

  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  exp_rdata = '0;
  bit          ref_ptr_cop = 1'b0;

  always #5 clk = ~clk;

  ram_bus_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mcu_req   (mcu_req),
    .mcu_we    (mcu_we),
    .mcu_addr  (mcu_addr),
    .mcu_wdata (mcu_wdata),
    .mcu_ack   (mcu_ack),
    .cop_req   (cop_req),
    .cop_we    (cop_we),
    .cop_addr  (cop_addr),
    .cop_wdata (cop_wdata),
    .cop_ack   (cop_ack),
    .rdata     (rdata),
    .busy      (busy),
    .ram_nss   (ram_nss),
    .ram_sck   (ram_sck),
    .ram_mosi  (ram_mosi),
    .ram_miso  (ram_miso)
  );

  // Serial RAM device: captures MOSI on SCK rise, drives MISO after SCK fall.
  always @(negedge ram_nss) begin
    spi_bits  = 0;
    spi_shift = '0;
    last_gap  = $time - rise_t;
  end

  always @(posedge ram_sck) begin
    if (ram_nss === 1'b0) begin
      spi_shift = {spi_shift[30:0], ram_mosi};
      spi_bits++;
      if (spi_bits == 24) spi_rd_byte = ram_mem[spi_shift[15:0]];
    end
  end

  always @(posedge ram_nss) begin
    last_frame = spi_shift;
    last_bits  = spi_bits;
    rise_t     = $time;
    if (spi_bits == 32 && spi_shift[31:24] == 8'h02) ram_mem[spi_shift[23:8]] = spi_shift[7:0];
    spi_bits = 0;
  end

  always @(negedge ram_sck) begin
    #1;
    if (spi_bits >= 24 && spi_bits < 32) ram_miso = spi_rd_byte[31 - spi_bits];
    else ram_miso = 1'($urandom);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic mr, input logic cr, input logic mw, input logic cw,
                                input logic [15:0] ma, input logic [15:0] ca,
                                input logic [7:0] md, input logic [7:0] cd);
    mcu_req = mr; cop_req = cr; mcu_we = mw; cop_we = cw;
    mcu_addr = ma; cop_addr = ca; mcu_wdata = md; cop_wdata = cd;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_output("idle_timeout", 32'(busy), 32'h0);
  endtask

  // One transaction from the current request inputs; ack expected 66 cycles after the grant cycle.
  task automatic run_txn(input bit hold, input int tamper_k, input logic [15:0] tamper_addr,
                         output bit served_cop);
    bit          win_cop, we, early, busy_low;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] exp_frame;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (mcu_req && cop_req) win_cop = ref_ptr_cop;
    else win_cop = cop_req && !mcu_req;
`else
    win_cop = cop_req && !mcu_req;
`endif
    we   = win_cop ? cop_we : mcu_we;
    addr = win_cop ? cop_addr : mcu_addr;
    data = win_cop ? cop_wdata : mcu_wdata;
    exp_frame = {(we ? 8'h02 : 8'h03), addr, (we ? data : 8'h00)};
    if (we) ref_mem[addr] = data;
    else exp_rdata = ref_mem[addr];
    early = 1'b0;
    busy_low = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (k == tamper_k) begin
        mcu_req  = 1'b0;
        mcu_addr = tamper_addr;
      end
      if (k < 66) begin
        if (mcu_ack !== 1'b0 || cop_ack !== 1'b0) early = 1'b1;
        if (busy !== 1'b1) busy_low = 1'b1;
      end
    end
    check_output("mcu_ack", 32'(mcu_ack), 32'(!win_cop));
    check_output("cop_ack", 32'(cop_ack), 32'(win_cop));
    check_output("rdata", 32'(rdata), 32'(exp_rdata));
    check_output("early_ack", 32'(early), 32'h0);
    check_output("busy_during", 32'(busy_low), 32'h0);
    check_output("frame", last_frame, exp_frame);
    check_output("frame_bits", 32'(last_bits), 32'd32);
    if (!hold) apply_stimulus(0, 0, 0, 0, mcu_addr, cop_addr, mcu_wdata, cop_wdata);
    ref_ptr_cop = !win_cop;
    served_cop = win_cop;
    @(negedge clk);
    check_output("ack_width", 32'({mcu_ack, cop_ack}), 32'h0);
  endtask

  initial begin
    bit          sc;
    logic [15:0] a;
    logic [3:0]  grants;
    logic [3:0]  exp_grants;
    for (int i = 0; i < 65536; i++) begin
      a = 16'(i);
      ram_mem[i] = a[7:0] ^ a[15:8] ^ 8'hC3;
      ref_mem[i] = a[7:0] ^ a[15:8] ^ 8'hC3;
    end

    #2 reset_n = 1'b0;
    #1;
    $display("[TB] reset state");
    check_output("rst_nss", 32'(ram_nss), 32'h1);
    check_output("rst_sck_mosi", 32'({ram_sck, ram_mosi}), 32'h0);
    check_output("rst_busy_acks", 32'({busy, mcu_ack, cop_ack}), 32'h0);
    check_output("rst_rdata", 32'(rdata), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] MCU write 0x1234 <- 0xA5");
    wait_idle();
    apply_stimulus(1, 0, 1, 0, 16'h1234, 16'h0000, 8'hA5, 8'h00);
    run_txn(0, 0, 16'h0, sc);
    check_output("frame_021234A5", last_frame, 32'h021234A5);

    $display("[TB] COP read 0x00FF");
    ram_mem[16'h00FF] = 8'h5A;
    ref_mem[16'h00FF] = 8'h5A;
    wait_idle();
    apply_stimulus(0, 1, 0, 0, 16'h0000, 16'h00FF, 8'h00, 8'h00);
    run_txn(0, 0, 16'h0, sc);
    check_output("frame_0300FF00", last_frame, 32'h0300FF00);
    check_output("rdata_5A", 32'(rdata), 32'h5A);

    $display("[TB] simultaneous requests held x4");
    wait_idle();
    apply_stimulus(1, 1, 1, 1, 16'h0010, 16'h0020, 8'h11, 8'h22);
    for (int t = 0; t < 4; t++) begin
      wait_idle();
      run_txn(1, 0, 16'h0, sc);
      grants[t] = sc;
      if (t == 1) check_output("nss_gap_cycles", 32'(last_gap / 10), 32'd2);
    end
    apply_stimulus(0, 0, 0, 0, 16'h0, 16'h0, 8'h0, 8'h0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_grants = 4'b1010;
`else
    exp_grants = 4'b0000;
`endif
    check_output("grant_order", 32'(grants), 32'(exp_grants));

    $display("[TB] request dropped and address changed after grant");
    wait_idle();
    apply_stimulus(1, 0, 0, 0, 16'h0020, 16'h0000, 8'h00, 8'h00);
    run_txn(0, 5, 16'hBEEF, sc);

    $display("[TB] reset during SHIFT bit 10");
    wait_idle();
    apply_stimulus(1, 0, 1, 0, 16'h0333, 16'h0000, 8'h77, 8'h00);
    @(posedge clk);
    repeat (21) @(posedge clk);
    @(negedge clk);
    check_output("abort_point_bits", 32'(spi_bits), 32'd10);
    reset_n = 1'b0;
    #1;
    check_output("abort_nss", 32'(ram_nss), 32'h1);
    check_output("abort_sck_mosi", 32'({ram_sck, ram_mosi}), 32'h0);
    check_output("abort_busy_rdata", 32'({busy, rdata}), 32'h0);
    apply_stimulus(0, 0, 0, 0, 16'h0, 16'h0, 8'h0, 8'h0);
    exp_rdata = '0;
    ref_ptr_cop = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sc = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (mcu_ack !== 1'b0 || cop_ack !== 1'b0) sc = 1'b1;
    end
    check_output("abort_no_ack", 32'(sc), 32'h0);
    check_output("abort_partial_bits", 32'(last_bits), 32'd10);
    wait_idle();
    apply_stimulus(1, 0, 0, 0, 16'h0333, 16'h0000, 8'h00, 8'h00);
    run_txn(0, 0, 16'h0, sc);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      wait_idle();
      apply_stimulus(r[0], r[1], 1'($urandom), 1'($urandom),
                     16'h0040 + 16'($urandom_range(0, 7)), 16'h0040 + 16'($urandom_range(0, 7)),
                     8'($urandom), 8'($urandom));
      run_txn(0, 0, 16'h0, sc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
